// File: rtl/tinker_arb_pkg.sv
// Shared types and constants for the tinker memory-port arbiter.
// Purely declarative: no logic, no latency, no flow control of its own.
package tinker_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    localparam logic SIZE_WORD   = 1'b0;
    localparam logic SIZE_DWORD  = 1'b1;

    localparam longint unsigned DEF_MEM_BYTES = 64'd524288;

endpackage

// File: rtl/tinker_arb_prio.sv
// Fetch/data winner select with a saturating data-streak counter; combinational grant.
// A ready is raised only for a valid winner while the arbiter is idle; everything else waits.
module tinker_arb_prio
    import tinker_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_idle,
    input  logic i_if_vld,
    input  logic i_d_vld,
    output logic o_if_rdy,
    output logic o_d_rdy
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    logic [SW-1:0] r_streak;
    logic          w_streak_full;
    logic          w_fetch_win;

    assign w_streak_full = (r_streak == SW'(MAX_DATA_STREAK));
    // Data normally wins; a pending fetch is forced through once the streak is exhausted.
    assign w_fetch_win   = i_if_vld && (!i_d_vld || w_streak_full);
    assign o_if_rdy      = i_idle && w_fetch_win;
    assign o_d_rdy       = i_idle && i_d_vld && !w_fetch_win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_streak <= '0;
        end else if (o_if_rdy) begin
            r_streak <= '0;
        end else if (o_d_rdy) begin
            if (!i_if_vld) begin
                r_streak <= '0;
            end else if (!w_streak_full) begin
                r_streak <= r_streak + SW'(1);
            end
        end
    end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Single-outstanding fetch/data arbiter for the tinker memory port; accept N -> mem_req N+1, mem_rsp M -> rsp M+1.
// Requesters see ready low while busy; mem fields hold until mem_req_ready. Optional timeout: TINKER_ARB_TIMEOUT_EN.
module tinker_mem_arbiter
    import tinker_arb_pkg::*;
#(
    parameter int unsigned     ADDR_W          = 64,
    parameter longint unsigned MEM_BYTES       = DEF_MEM_BYTES,
    parameter int unsigned     MAX_DATA_STREAK = 4
`ifdef TINKER_ARB_TIMEOUT_EN
    ,
    parameter int unsigned     TIMEOUT_CYCLES  = 64
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [63:0]       d_wdata,
    output logic              d_rsp_valid,
    output logic [63:0]       d_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_size,
    output logic [63:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              owner
);

    arb_state_t        r_state;
    logic              r_busy, r_owner, r_rsp_err;
    logic              r_mem_req_valid, r_mem_we, r_mem_size;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [63:0]       r_mem_wdata, r_d_rsp_data;
    logic              r_if_rsp_valid, r_d_rsp_valid;
    logic [31:0]       r_if_rsp_data;

    logic              w_idle, w_if_rdy, w_d_rdy, w_acc;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [ADDR_W:0]   w_sel_end;
    logic              w_oob_acc, w_mem_done, w_timeout, w_enter_resp, w_resp_owner;

    tinker_arb_prio #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_prio (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_idle   (w_idle),
        .i_if_vld (if_req_valid),
        .i_d_vld  (d_req_valid),
        .o_if_rdy (w_if_rdy),
        .o_d_rdy  (w_d_rdy)
    );

    assign w_idle     = (r_state == IDLE);
    assign w_acc      = w_if_rdy || w_d_rdy;
    assign w_sel_addr = w_d_rdy ? d_addr : if_addr;
    // One extra bit so an access near the top of the address space cannot wrap past the check.
    assign w_sel_end  = {1'b0, w_sel_addr} + (w_d_rdy ? (ADDR_W+1)'(8) : (ADDR_W+1)'(4));
    assign w_oob_acc  = w_acc && (w_sel_end > (ADDR_W+1)'(MEM_BYTES));
    assign w_mem_done = ((r_state == ISSUE) && mem_req_ready && mem_rsp_valid) ||
                        ((r_state == WAIT) && mem_rsp_valid);

`ifdef TINKER_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = ((r_state == ISSUE) || (r_state == WAIT)) && !w_mem_done &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_enter_resp = w_oob_acc || w_mem_done || w_timeout;
    assign w_resp_owner = w_oob_acc ? w_d_rdy : r_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_owner         <= OWNER_FETCH;
            r_rsp_err       <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_we        <= 1'b0;
            r_mem_size      <= SIZE_WORD;
            r_mem_wdata     <= '0;
            r_if_rsp_valid  <= 1'b0;
            r_if_rsp_data   <= '0;
            r_d_rsp_valid   <= 1'b0;
            r_d_rsp_data    <= '0;
        end else begin
            if (w_idle && w_acc) begin
                r_busy      <= 1'b1;
                r_owner     <= w_d_rdy ? OWNER_DATA : OWNER_FETCH;
                r_mem_addr  <= w_sel_addr;
                r_mem_we    <= w_d_rdy && d_we;
                r_mem_size  <= w_d_rdy ? SIZE_DWORD : SIZE_WORD;
                r_mem_wdata <= w_d_rdy ? d_wdata : 64'd0;
                if (!w_oob_acc) begin
                    r_state         <= ISSUE;
                    r_mem_req_valid <= 1'b1;
                end
            end
            if ((r_state == ISSUE) && mem_req_ready && !mem_rsp_valid) begin
                r_state         <= WAIT;
                r_mem_req_valid <= 1'b0;
            end
            // Later assignments win: any completion, error or timeout lands in RESP.
            if (w_enter_resp) begin
                r_state         <= RESP;
                r_mem_req_valid <= 1'b0;
                r_rsp_err       <= !w_mem_done;
                if (w_resp_owner == OWNER_DATA) begin
                    r_d_rsp_valid <= 1'b1;
                    r_d_rsp_data  <= (w_mem_done && !r_mem_we) ? mem_rdata : 64'd0;
                end else begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rsp_data  <= w_mem_done ? mem_rdata[31:0] : 32'd0;
                end
            end
            if (r_state == RESP) begin
                r_state        <= IDLE;
                r_busy         <= 1'b0;
                r_rsp_err      <= 1'b0;
                r_if_rsp_valid <= 1'b0;
                r_d_rsp_valid  <= 1'b0;
            end
        end
    end

    assign if_req_ready  = w_if_rdy;
    assign d_req_ready   = w_d_rdy;
    assign if_rsp_valid  = r_if_rsp_valid;
    assign if_rsp_data   = r_if_rsp_data;
    assign d_rsp_valid   = r_d_rsp_valid;
    assign d_rsp_data    = r_d_rsp_data;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_size      = r_mem_size;
    assign mem_wdata     = r_mem_wdata;
    assign rsp_err       = r_rsp_err;
    assign busy          = r_busy;
    assign owner         = r_owner;

endmodule
